commitment_stream: RTL and testbench

Downstream of the per-round commitment stage: captures the 15 × 256-bit party commitments on the rising edge of that stage's `com_end` and streams them as 64-bit words into the challenge-hash absorber. The absorber uses a valid/ready handshake. The block buffers one full commitment set, so the upstream stage can begin the next round while the stream drains.

---
 rtl/commitment_stream.sv | 86 ++++++++
 tb/tb_commitment_stream.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/commitment_stream.sv
// commitment_stream: captures one 15x256-bit commitment set and streams it as 64-bit valid/ready words.
// Define COMMIT_STREAM_HDR_EN to prepend a {48'h0, 8'd15, t} header word to each set.
module commitment_stream #(
    parameter int WORD_W  = 64,
    parameter int N_PARTY = 15,
    parameter int COM_W   = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PARTY*COM_W-1:0]   C,
    input  logic [7:0]                 t,
    input  logic                       com_end,
    output logic                       load_ack,
    output logic [WORD_W-1:0]          word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       word_last,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf
);
    localparam int BUF_W   = N_PARTY * COM_W;
    localparam int N_WORDS = BUF_W / WORD_W;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state, state_nx;
    logic              com_end_q;
    logic [BUF_W-1:0]  sbuf;
    logic [7:0]        t_reg;
    logic [5:0]        cnt;
    logic              cap, xfer, hdr;
    logic [WORD_W-1:0] hdr_word;

`ifdef COMMIT_STREAM_HDR_EN
    localparam logic [5:0] LAST = 6'(N_WORDS);
    assign hdr = cnt == 6'd0;
`else
    localparam logic [5:0] LAST = 6'(N_WORDS - 1);
    assign hdr = 1'b0;
`endif

    assign cap        = com_end & ~com_end_q;
    assign word_valid = state == STREAM;
    assign busy       = word_valid;
    assign done       = state == DONE;
    assign xfer       = word_valid & word_ready;
    assign word_last  = word_valid & (cnt == LAST);
    assign hdr_word   = {{(WORD_W-16){1'b0}}, 8'(N_PARTY), t_reg};
    // The buffer shifts left on each data transfer, so the current word is always its top slice.
    assign word_out   = !word_valid ? '0 : hdr ? hdr_word : sbuf[BUF_W-1 -: WORD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE && cap) ? STREAM :
                   (xfer && word_last)    ? DONE   :
                   (state == DONE)        ? IDLE   : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_end_q <= 1'b0;
            load_ack  <= 1'b0;
            ovf       <= 1'b0;
            sbuf      <= '0;
            t_reg     <= '0;
            cnt       <= '0;
        end else begin
            com_end_q <= com_end;
            load_ack  <= cap && state == IDLE;
            ovf       <= ovf | (cap && state != IDLE);
            if (cap && state == IDLE) begin
                sbuf  <= C;
                t_reg <= t;
                cnt   <= '0;
            end else if (xfer) begin
                if (!word_last) cnt <= cnt + 6'd1;
                if (!hdr) sbuf <= {sbuf[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
            end
        end
    end
endmodule

// File: tb/tb_commitment_stream.sv
// tb_commitment_stream: directed/randomized bench for commitment_stream against a per-commitment word model.
// Honors COMMIT_STREAM_HDR_EN the same way as the design.
module tb_commitment_stream;
    localparam int NP = 15;
    localparam int CW = 256;
`ifdef COMMIT_STREAM_HDR_EN
    localparam int NW = 61;
`else
    localparam int NW = 60;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NP*CW-1:0] C = '0;
    logic [7:0]     t = '0;
    logic           com_end = 1'b0;
    logic           word_ready = 1'b0;
    logic           load_ack, word_valid, word_last, busy, done, ovf;
    logic [63:0]    word_out;

    int             vectors = 0;
    int             miscompares = 0;
    logic [63:0]    expq[$];
    logic           exp_ovf = 1'b0;

    always #5 clk = ~clk;

    commitment_stream dut (
        .clk(clk), .reset(reset), .C(C), .t(t), .com_end(com_end),
        .load_ack(load_ack), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .word_last(word_last), .busy(busy),
        .done(done), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zeros(input string p);
        check({p, "_load_ack"}, load_ack, 0);
        check({p, "_word_out"}, word_out, 0);
        check({p, "_word_valid"}, word_valid, 0);
        check({p, "_word_last"}, word_last, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_ovf"}, ovf, 0);
    endtask

    // Builds a set from per-party commitments; expected words are each commitment split MSB-first.
    task automatic load_set(input bit pattern, input logic [7:0] tv);
        logic [CW-1:0] com;
        expq.delete();
        C = '0;
        t = tv;
`ifdef COMMIT_STREAM_HDR_EN
        expq.push_back({48'h0, 8'd15, tv});
`endif
        for (int i = 0; i < NP; i++) begin
            com = pattern ? {4{56'h0, 8'(i)}}
                          : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            C = {C[NP*CW-CW-1:0], com};
            for (int j = 0; j < 4; j++) expq.push_back(64'(com >> (CW - 64 * (j + 1))));
        end
        com_end = 1'b1;
        @(negedge clk);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    task automatic drain(input int mode, input int ovf_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit raise;
        while (idx < NW && cyc < 600) begin
            if (idx == abort_at) begin
                reset = 1'b0;
                #1;
                zeros("rst_mid");
                exp_ovf = 1'b0;
                return;
            end
            check("load_ack", load_ack, cyc == 0);
            check("word_valid", word_valid, 1);
            check("busy", busy, 1);
            check("word_out", word_out, expq[idx]);
            check("word_last", word_last, idx == NW - 1);
            check("done_low", done, 0);
            check("ovf", ovf, exp_ovf);
            if (ovf_at >= 0 && cyc == 2) com_end = 1'b0;
            raise = 1'b0;
            if (idx == ovf_at && !com_end) begin
                com_end = 1'b1;
                raise = 1'b1;
            end
            word_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom);
            if (word_ready) idx++;
            @(negedge clk);
            cyc++;
            if (raise) exp_ovf = 1'b1;
        end
        word_ready = 1'b0;
        check("transfer_count", idx, NW);
        check("end_valid", word_valid, 0);
        check("end_busy", busy, 0);
        check("end_last", word_last, 0);
        check("end_word_out", word_out, 0);
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_valid", word_valid, 0);
        check("idle_ovf", ovf, exp_ovf);
    endtask

    initial begin
        #1;
        zeros("reset");
        repeat (2) @(negedge clk);
        zeros("reset_hold");
        reset = 1'b1;
        @(negedge clk);
        zeros("post_reset");

        load_set(1'b1, 8'h2A);
        drain(0, -1, -1);

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(1, -1, -1);

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(2, -1, -1);

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(0, -1, -1);
        repeat (140) begin
            check("level_load_ack", load_ack, 0);
            check("level_valid", word_valid, 0);
            check("level_ovf", ovf, 0);
            @(negedge clk);
        end

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(1, 20, -1);
        check("ovf_set", ovf, 1);

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(2, -1, -1);
        check("ovf_sticky", ovf, 1);

        com_end = 1'b0;
        @(negedge clk);
        load_set(1'b0, 8'($urandom));
        drain(0, -1, 30);
        com_end = 1'b0;
        repeat (2) @(negedge clk);
        zeros("rst_hold2");
        reset = 1'b1;
        @(negedge clk);
        zeros("rst_release");
        load_set(1'b0, 8'($urandom));
        drain(1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
